// File: rtl/module_display_scan_if.sv
// +----------------------------------------------------------------------------+
// | Module   : module_display_scan_if                                          |
// | Purpose  : Bundles the load-side bus and the display-side outputs of the   |
// |            7-segment scanner into one connection.                          |
// | Signals  : value       4*N_DIGITS hex nibbles, digit 0 in bits [3:0]       |
// |            dp_mask     N_DIGITS   1 = decimal point on for digit k         |
// |            blank_mask  N_DIGITS   1 = digit k dark                         |
// |            load        1          single-cycle capture strobe              |
// |            data        4          nibble to the 7-segment decoder          |
// |            dp          1          active-low decimal point                 |
// |            an          N_DIGITS   active-low digit anodes                  |
// |            digit_idx   IDX_W      current or most recent digit index       |
// |            frame_start 1          pulse on first SHOW cycle of digit 0     |
// | Modports : master drives value/dp_mask/blank_mask/load,                    |
// |            slave (the scanner) drives the display-side outputs.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface module_display_scan_if #(
  parameter int N_DIGITS = 4
);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_mask;
  logic [N_DIGITS-1:0]   blank_mask;
  logic                  load;

  logic [3:0]            data;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_start;

  modport master (
    output value, dp_mask, blank_mask, load,
    input  data, dp, an, digit_idx, frame_start
  );

  modport slave (
    input  value, dp_mask, blank_mask, load,
    output data, dp, an, digit_idx, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/module_display_scan.sv
// +----------------------------------------------------------------------------+
// | Module   : module_display_scan                                             |
// | Purpose  : Time-multiplexed scanner for an N-digit common-anode 7-segment  |
// |            display. Feeds one nibble + decimal point per slot to the       |
// |            downstream decoder and drives the active-low anodes. Loaded     |
// |            values are double-buffered and only become visible at a frame   |
// |            boundary; a guard slot with all anodes off separates digits.    |
// | Ports    : clk      system clock (rising edge)                             |
// |            rst_n    synchronous active-low reset                           |
// |            io_scan  module_display_scan_if.slave                           |
// |                     in : value, dp_mask, blank_mask, load                  |
// |                     out: data, dp, an, digit_idx, frame_start              |
// | Params   : N_DIGITS (2..8), REFRESH_DIV (>=1), GUARD_CYCLES (0 = none)     |
// | Option   : LEADING_ZERO_BLANK_EN - when defined, digits above the most     |
// |            significant nonzero nibble are forced dark (digit 0 never).     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module module_display_scan #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  module_display_scan_if.slave  io_scan
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_IDX_W   = $clog2(N_DIGITS);
  localparam int c_CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_SHOW_LAST  = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_GUARD_LAST =
      c_CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(N_DIGITS - 1);

  localparam logic [0:0] c_SHOW  = 1'b0;
  localparam logic [0:0] c_GUARD = 1'b1;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [4*N_DIGITS-1:0] r_pend_value;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic [N_DIGITS-1:0]   r_pend_blank;
  logic [4*N_DIGITS-1:0] r_act_value;
  logic [N_DIGITS-1:0]   r_act_dp;
  logic [N_DIGITS-1:0]   r_act_blank;
  logic [c_IDX_W-1:0]    r_idx;
  logic [0:0]            r_state;
  logic [c_CNT_W-1:0]    r_cnt;
`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0]   r_lz_mask;
`endif

  // --------------------------------------------------------------------------
  // Sequencing decode
  // --------------------------------------------------------------------------
  logic                  w_show_last;
  logic                  w_guard_last;
  logic                  w_advance;
  logic                  w_boundary;
  logic [c_IDX_W-1:0]    w_idx_next;
  logic [4*N_DIGITS-1:0] w_cap_value;
  logic [N_DIGITS-1:0]   w_cap_dp;
  logic [N_DIGITS-1:0]   w_cap_blank;
  logic [N_DIGITS-1:0]   w_blank_eff;

  assign w_show_last  = (r_cnt == c_SHOW_LAST);
  // With no guard interval the post-reset GUARD state still lasts one cycle,
  // so the first SHOW of digit 0 always follows an all-dark cycle.
  assign w_guard_last = (GUARD_CYCLES == 0) || (r_cnt == c_GUARD_LAST);

  // The digit index moves on leaving GUARD, or leaving SHOW when there is
  // no guard interval between digits.
  assign w_advance  = (r_state == c_GUARD) ? w_guard_last
                                           : (w_show_last && (GUARD_CYCLES == 0));
  assign w_boundary = w_advance && (r_idx == c_LAST_IDX);
  assign w_idx_next = (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_W'(1);

  // A load on the boundary edge goes straight into the active copy so the
  // new value shows in the frame that is just starting.
  assign w_cap_value = io_scan.load ? io_scan.value      : r_pend_value;
  assign w_cap_dp    = io_scan.load ? io_scan.dp_mask    : r_pend_dp;
  assign w_cap_blank = io_scan.load ? io_scan.blank_mask : r_pend_blank;

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] w_lz_next;

  // Digit k is dark when every nibble from k up to the top is zero.
  // Digit 0 is excluded so an all-zero value still shows a single "0".
  always_comb begin : p_lz
    logic w_upper_zero;
    w_lz_next    = '0;
    w_upper_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      w_upper_zero = w_upper_zero && (w_cap_value[4*k +: 4] == 4'h0);
      w_lz_next[k] = w_upper_zero;
    end
  end

  assign w_blank_eff = r_act_blank | r_lz_mask;
`else
  assign w_blank_eff = r_act_blank;
`endif

  // --------------------------------------------------------------------------
  // State, counter and buffers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_idx        <= c_LAST_IDX;
      r_state      <= c_GUARD;
      r_cnt        <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      r_lz_mask    <= '0;
`endif
    end else begin
      // Pending always tracks the latest load, so the last load of a frame
      // wins and a boundary-edge load also persists into later frames.
      if (io_scan.load) begin
        r_pend_value <= io_scan.value;
        r_pend_dp    <= io_scan.dp_mask;
        r_pend_blank <= io_scan.blank_mask;
      end

      if (w_boundary) begin
        r_act_value <= w_cap_value;
        r_act_dp    <= w_cap_dp;
        r_act_blank <= w_cap_blank;
`ifdef LEADING_ZERO_BLANK_EN
        r_lz_mask   <= w_lz_next;
`endif
      end

      case (r_state)
        c_SHOW: begin
          if (w_show_last) begin
            r_cnt <= '0;
            if (GUARD_CYCLES == 0) begin
              r_idx <= w_idx_next;
            end else begin
              r_state <= c_GUARD;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_GUARD: begin
          if (w_guard_last) begin
            r_cnt   <= '0;
            r_idx   <= w_idx_next;
            r_state <= c_SHOW;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= c_GUARD;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (purely from registers)
  // --------------------------------------------------------------------------
  logic [3:0]          w_nib;
  logic                w_dark;
  logic [N_DIGITS-1:0] w_an;
  logic [3:0]          w_data;
  logic                w_dp;

  assign w_nib  = r_act_value[{r_idx, 2'b00} +: 4];
  assign w_dark = w_blank_eff[r_idx];

  // data/dp are the same in SHOW and GUARD so the decoder input stays stable
  // across the guard slot; only the anode is gated by state.
  always_comb begin
    w_an   = '1;
    w_data = w_dark ? 4'h0 : w_nib;
    w_dp   = w_dark ? 1'b1 : ~r_act_dp[r_idx];
    if ((r_state == c_SHOW) && !w_dark) begin
      w_an[r_idx] = 1'b0;
    end
  end

  assign io_scan.an          = w_an;
  assign io_scan.data        = w_data;
  assign io_scan.dp          = w_dp;
  assign io_scan.digit_idx   = r_idx;
  assign io_scan.frame_start = (r_state == c_SHOW) && (r_idx == '0) && (r_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_module_display_scan.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_module_display_scan                                          |
// | Purpose  : Directed, table-driven bench for module_display_scan with       |
// |            N_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1 (20-cycle frame).     |
// |            Expectations follow LEADING_ZERO_BLANK_EN when it is defined.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_module_display_scan;

  localparam int N = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit c_LZ = 1'b1;
`else
  localparam bit c_LZ = 1'b0;
`endif

  // Load inputs plus the hand-computed view of one frame showing them:
  // exp_data nibble per digit (0 where dark), active-low dp per digit,
  // and which digits stay dark for the whole slot.
  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpm;
    logic [3:0]  blk;
    logic [15:0] exp_data;
    logic [3:0]  exp_dpn;
    logic [3:0]  exp_dark;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  rec_t tbl [5];
  rec_t r_zero, r_bnd, r_m1, r_m2;

  module_display_scan_if #(.N_DIGITS(N)) u_if ();

  module_display_scan #(
    .N_DIGITS    (N),
    .REFRESH_DIV (4),
    .GUARD_CYCLES(1)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_scan(u_if.slave)
  );

  always #5 clk = ~clk;

  // Compares {an, data, dp, frame_start, digit_idx} against an expectation.
  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = {u_if.an, u_if.data, u_if.dp, u_if.frame_start, u_if.digit_idx};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got an_data_dp_fs_idx=%b expected %b", name, got, exp);
    end
  endtask

  task automatic apply_load(input rec_t r);
    u_if.value      = r.value;
    u_if.dp_mask    = r.dpm;
    u_if.blank_mask = r.blk;
    u_if.load       = 1'b1;
  endtask

  // Junk on the data inputs while load is low must never be captured.
  task automatic idle_inputs();
    u_if.value      = 16'($urandom);
    u_if.dp_mask    = 4'($urandom);
    u_if.blank_mask = 4'($urandom);
    u_if.load       = 1'b0;
  endtask

  // Entered at the negedge of a frame_start cycle; checks all 20 cycles of
  // the frame against 'cur' and optionally loads ra/rb at cycles ca/cb.
  // Returns at the negedge of the next frame's first cycle.
  task automatic run_frame(input string tag, input rec_t cur,
                           input int ca, input rec_t ra,
                           input int cb, input rec_t rb);
    for (int cyc = 0; cyc < 20; cyc++) begin
      int         d;
      logic       sh;
      logic [3:0] an_e;
      d    = cyc / 5;
      sh   = (cyc % 5) < 4;
      an_e = 4'b1111;
      if (sh && !cur.exp_dark[d]) an_e[d] = 1'b0;
      check($sformatf("%s cyc%0d", tag, cyc),
            {an_e, cur.exp_data[4*d +: 4], cur.exp_dpn[d], (cyc == 0), 2'(d)});
      if (cyc == ca)      apply_load(ra);
      else if (cyc == cb) apply_load(rb);
      else                idle_inputs();
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    r_zero = '{16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b1111,
               c_LZ ? 4'b1110 : 4'b0000};
    tbl[0] = '{16'h12AF, 4'b0100, 4'b0000, 16'h12AF, 4'b1011, 4'b0000};
    tbl[1] = '{16'h3C05, 4'b0011, 4'b1000, 16'h0C05, 4'b1100, 4'b1000};
    tbl[2] = '{16'h0050, 4'b0000, 4'b0000, 16'h0050, 4'b1111,
               c_LZ ? 4'b1100 : 4'b0000};
    tbl[3] = '{16'h0000, 4'b1111, 4'b0000, 16'h0000,
               c_LZ ? 4'b1110 : 4'b0000, c_LZ ? 4'b1110 : 4'b0000};
    tbl[4] = '{16'h0934, 4'b0001, 4'b0010, 16'h0904, 4'b1110,
               c_LZ ? 4'b1010 : 4'b0010};
    r_bnd  = '{16'h0007, 4'b0000, 4'b0000, 16'h0007, 4'b1111,
               c_LZ ? 4'b1110 : 4'b0000};
    r_m1   = '{16'h1111, 4'b1111, 4'b0000, 16'h1111, 4'b0000, 4'b0000};
    r_m2   = '{16'hBEEF, 4'b0000, 4'b0000, 16'hBEEF, 4'b1111, 4'b0000};

    // Reset: all dark, data 0, dp off, idx = 3.
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset", {4'b1111, 4'h0, 1'b1, 1'b0, 2'd3});
    rst_n = 1'b1;
    // The reset cycle is the single guard cycle; next cycle starts the frame.
    @(negedge clk);

    // Each frame shows the previous record while the next one is loaded
    // mid-frame, proving the load only lands at the boundary.
    run_frame("frame0", r_zero, 7, tbl[0], -1, r_zero);
    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("rec%0d", i), tbl[i], 7, tbl[i+1], -1, r_zero);
    end
    // Load on the guard cycle of digit 3 coincides with the boundary edge.
    run_frame("rec4", tbl[4], 19, r_bnd, -1, r_zero);
    // Boundary-load value shows immediately; two loads follow in this frame.
    run_frame("bndload", r_bnd, 3, r_m1, 12, r_m2);
    run_frame("lastwins", r_m2, -1, r_zero, -1, r_zero);

    // Reset during the SHOW of digit 2.
    repeat (11) @(negedge clk);
    check("digit2 before reset", {4'b1011, 4'hE, 1'b1, 1'b0, 2'd2});
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-frame reset", {4'b1111, 4'h0, 1'b1, 1'b0, 2'd3});
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("after-reset", r_zero, -1, r_zero, -1, r_zero);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
